// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, line levels and a
// counter-width helper used to size the receiver's internal counters.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

    // Width needed to count to n-1, never less than one bit so that
    // degenerate configurations still get a real register.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/uart_receive_if.sv
// Receiver-side bus: serial line in, parallel word and status pulses out.
// The master modport is the receiver itself; the slave modport is whatever
// drives the line and consumes the received words.
interface uart_receive_if #(
    parameter int D_WIDTH = 4
);

    logic               rx;
    logic [D_WIDTH-1:0] rx_data;
    logic               rx_valid;
    logic               rx_frame_err;
    logic               rx_busy;

    modport master (
        input  rx,
        output rx_data,
        output rx_valid,
        output rx_frame_err,
        output rx_busy
    );

    modport slave (
        output rx,
        input  rx_data,
        input  rx_valid,
        input  rx_frame_err,
        input  rx_busy
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous serial line. Both flops reset to
// the idle level so that leaving reset never looks like a start bit.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the line through two flops; reset forces the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= UART_IDLE_LVL;
            q    <= UART_IDLE_LVL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receive.sv
// UART receiver: start/stop checked serial frames, LSB first, converted to
// parallel words with one-cycle valid or framing-error pulses.
// Optional macro UART_RX_SYNC_EN inserts a 2-flop synchroniser on rx
// (adds two cycles of latency); without it rx is sampled directly.
module uart_receive
    import uart_pkg::*;
#(
    parameter int D_WIDTH = 4,
    parameter int OS_RATE = 1
) (
    input logic              clk,
    input logic              rst,
    uart_receive_if.master   bus
);

    localparam int OS_W  = cnt_width(OS_RATE);
    localparam int BIT_W = cnt_width(D_WIDTH + 1);
    localparam int HALF  = (OS_RATE - 1) / 2;

    localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(HALF);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OS_RATE - 1);
    localparam logic [OS_W-1:0]  OS_ONE   = OS_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(D_WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.rx),
        .q   (rx_s)
    );
`else
    assign rx_s = bus.rx;
`endif

    rx_state_t          state_q, state_d;
    logic [OS_W-1:0]    os_cnt_q, os_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [D_WIDTH-1:0] shift_q, shift_d;
    logic [D_WIDTH-1:0] data_q, data_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic [D_WIDTH:0]   shift_ext;

    // New bit enters at the MSB; the concatenation keeps this legal for D_WIDTH=1.
    assign shift_ext = {rx_s, shift_q};

    // State and datapath registers; reset discards any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            os_cnt_q  <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            os_cnt_q  <= os_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    // Frame sequencing: confirm start mid-bit, sample data mid-bit, check stop.
    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_s == UART_START_LVL) begin
                    os_cnt_d = '0;
                    state_d  = START;
                end
            end

            START: begin
                if (os_cnt_q == OS_HALF) begin
                    if (rx_s == UART_IDLE_LVL) begin
                        state_d = IDLE;
                    end else begin
                        os_cnt_d  = '0;
                        bit_cnt_d = '0;
                        state_d   = DATA;
                    end
                end else begin
                    os_cnt_d = os_cnt_q + OS_ONE;
                end
            end

            DATA: begin
                if (os_cnt_q == OS_LAST) begin
                    shift_d   = shift_ext[D_WIDTH:1];
                    bit_cnt_d = bit_cnt_q + BIT_ONE;
                    os_cnt_d  = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = STOP;
                    end
                end else begin
                    os_cnt_d = os_cnt_q + OS_ONE;
                end
            end

            STOP: begin
                if (os_cnt_q == OS_LAST) begin
                    os_cnt_d = '0;
                    if (rx_s == UART_IDLE_LVL) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    os_cnt_d = os_cnt_q + OS_ONE;
                end
            end

            BREAK: begin
                if (rx_s == UART_IDLE_LVL) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.rx_data      = data_q;
    assign bus.rx_valid     = valid_q;
    assign bus.rx_frame_err = err_q;
    assign bus.rx_busy      = (state_q != IDLE);

endmodule
